aes_round_sequencer: RTL and testbench

//  Top-level round controller for the AES-128 core. On one start pulse it steps round_num 1..NUM_ROUNDS.
//  For each round it first runs keyExpansion (enable/expansionDone), then the cipher round datapath
//  (rnd_enable/rnd_done). It owns the holdoff keyExpansion needs after expansionDone, and has a
//  per-wait timeout and an abort path.

---
 rtl/aes_round_sequencer.sv | 153 +++++++++++++++
 tb/tb_aes_round_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Round controller for AES-128: steps round_num 1..NUM_ROUNDS, running keyExpansion then the round datapath each round.
// All outputs are registered; enables and done are single-cycle pulses, waits are bounded by a saturating timer.
module aes_round_sequencer #(
    parameter int unsigned NUM_ROUNDS   = 10,
    parameter int unsigned KEXP_HOLDOFF = 5,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       kexp_done,
    input  logic       rnd_done,
    output logic [3:0] round_num,
    output logic       kexp_enable,
    output logic       rnd_enable,
    output logic       rnd_last,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP_REQ,
        S_KEXP_WAIT,
        S_HOLD,
        S_RND_REQ,
        S_RND_WAIT,
        S_FINISH
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [7:0] HOLD_LAST  = 8'(KEXP_HOLDOFF - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] timer;

    // Outputs are assigned alongside each transition so they reflect the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= 8'd0;
            round_num   <= 4'd0;
            kexp_enable <= 1'b0;
            rnd_enable  <= 1'b0;
            rnd_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            kexp_enable <= 1'b0;
            rnd_enable  <= 1'b0;
            done        <= 1'b0;

            if (abort && (state != S_IDLE)) begin
                state    <= S_IDLE;
                timer    <= 8'd0;
                busy     <= 1'b0;
                rnd_last <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state       <= S_KEXP_REQ;
                            timer       <= 8'd0;
                            round_num   <= 4'd1;
                            error       <= 1'b0;
                            kexp_enable <= 1'b1;
                            busy        <= 1'b1;
                            rnd_last    <= (LAST_ROUND == 4'd1);
                        end
                    end

                    S_KEXP_REQ: begin
                        state <= S_KEXP_WAIT;
                        timer <= 8'd0;
                    end

                    // A done in the final allowed cycle still wins over the timeout.
                    S_KEXP_WAIT: begin
                        if (kexp_done) begin
                            state <= S_HOLD;
                            timer <= 8'd0;
                        end else if (timer >= TMO_LAST) begin
                            state    <= S_IDLE;
                            timer    <= 8'd0;
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            rnd_last <= 1'b0;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end

                    S_HOLD: begin
                        if (timer >= HOLD_LAST) begin
                            state      <= S_RND_REQ;
                            timer      <= 8'd0;
                            rnd_enable <= 1'b1;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end

                    S_RND_REQ: begin
                        state <= S_RND_WAIT;
                        timer <= 8'd0;
                    end

                    S_RND_WAIT: begin
                        if (rnd_done) begin
                            timer <= 8'd0;
                            if (round_num == LAST_ROUND) begin
                                state <= S_FINISH;
                                done  <= 1'b1;
                            end else begin
                                state       <= S_KEXP_REQ;
                                round_num   <= round_num + 4'd1;
                                kexp_enable <= 1'b1;
                                rnd_last    <= ((round_num + 4'd1) == LAST_ROUND);
                            end
                        end else if (timer >= TMO_LAST) begin
                            state    <= S_IDLE;
                            timer    <= 8'd0;
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            rnd_last <= 1'b0;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end

                    // round_num is left at the last round until the next start.
                    S_FINISH: begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        rnd_last <= 1'b0;
                    end

                    default: begin
                        state    <= S_IDLE;
                        timer    <= 8'd0;
                        busy     <= 1'b0;
                        rnd_last <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: nominal run, holdoff, timeout, abort, stray inputs, async reset.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort, kexp_done, rnd_done;
    logic [3:0] round_num;
    logic       kexp_enable, rnd_enable, rnd_last, busy, done, error;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(
        .NUM_ROUNDS  (10),
        .KEXP_HOLDOFF(5),
        .TIMEOUT     (255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .kexp_done  (kexp_done),
        .rnd_done   (rnd_done),
        .round_num  (round_num),
        .kexp_enable(kexp_enable),
        .rnd_enable (rnd_enable),
        .rnd_last   (rnd_last),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Cycle k is the interval after edge k-1; inputs set while cyc==k are sampled at edge k.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic go_idle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_to_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        rst = 1'b1; start = 1'b0; abort = 1'b0; kexp_done = 1'b0; rnd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        outs = {round_num, kexp_enable, rnd_enable, rnd_last, busy, done, error};
        checks++;
        if (outs !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000000", outs);
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || kexp_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b kexp_enable=%b expected 0 0", busy, kexp_enable);
        end
    endtask

    task automatic test_nominal();
        int ken = -100, ren = -100, nken = 0, nren = 0, ndone = 0, done_cyc = -1;
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (kexp_enable) begin
                nken++;
                checks++;
                if (nken > 1 && cyc !== ren + 5) begin
                    errors++;
                    $display("FAIL nominal_kexp_cycle: cycle %0d expected %0d", cyc, ren + 5);
                end
                ken = cyc;
                checks++;
                if (round_num !== 4'(nken)) begin
                    errors++;
                    $display("FAIL nominal_round_num: got %0d expected %0d", round_num, nken);
                end
            end
            if (rnd_enable) begin
                nren++;
                checks++;
                if (cyc !== ken + 9) begin
                    errors++;
                    $display("FAIL nominal_holdoff: rnd_enable cycle %0d expected %0d", cyc, ken + 9);
                end
                checks++;
                if (rnd_last !== (nren == 10)) begin
                    errors++;
                    $display("FAIL nominal_rnd_last: round %0d rnd_last=%b expected %b", nren, rnd_last, nren == 10);
                end
                ren = cyc;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                break;
            end
            kexp_done = (cyc == ken + 3);
            rnd_done  = (cyc == ren + 4);
            tick();
        end
        kexp_done = 1'b0;
        rnd_done  = 1'b0;
        checks++;
        if (nken !== 10 || nren !== 10 || ndone !== 1) begin
            errors++;
            $display("FAIL nominal_counts: kexp=%0d rnd=%0d done=%0d expected 10 10 1", nken, nren, ndone);
        end
        checks++;
        if (done_cyc !== 141) begin
            errors++;
            $display("FAIL nominal_done_cycle: got %0d expected 141", done_cyc);
        end
        // start during the FINISH cycle must not launch a new sequence
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || kexp_enable !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL finish_start_ignored: busy=%b kexp_enable=%b done=%b expected 0 0 0", busy, kexp_enable, done);
        end
        checks++;
        if (round_num !== 4'd10 || error !== 1'b0 || rnd_last !== 1'b0) begin
            errors++;
            $display("FAIL nominal_final: round_num=%0d error=%b rnd_last=%b expected 10 0 0", round_num, error, rnd_last);
        end
    endtask

    task automatic test_holdoff();
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (kexp_enable !== 1'b1) begin
            errors++;
            $display("FAIL holdoff_kexp_enable: got %b expected 1", kexp_enable);
        end
        tick();
        kexp_done = 1'b1;
        tick();
        kexp_done = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            checks++;
            if (rnd_enable !== 1'b0 || kexp_enable !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL holdoff_window: cycle %0d rnd_enable=%b kexp_enable=%b busy=%b expected 0 0 1",
                         k, rnd_enable, kexp_enable, busy);
            end
            tick();
        end
        checks++;
        if (rnd_enable !== 1'b1) begin
            errors++;
            $display("FAIL holdoff_rnd_enable: cycle 8 rnd_enable=%b expected 1", rnd_enable);
        end
        go_idle();
    endtask

    task automatic test_timeout();
        int ken = -100, ren = -100, stall = -1, ndone = 0;
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (kexp_enable) begin
                ken = cyc;
                if (round_num == 4'd3) begin
                    stall = cyc;
                    break;
                end
            end
            if (rnd_enable) ren = cyc;
            kexp_done = (cyc == ken + 3);
            rnd_done  = (cyc == ren + 4);
            tick();
        end
        kexp_done = 1'b0;
        rnd_done  = 1'b0;
        checks++;
        if (stall !== 29) begin
            errors++;
            $display("FAIL timeout_round3_start: cycle %0d expected 29", stall);
        end
        while (cyc < stall + 255) begin
            tick();
            if (done) ndone++;
        end
        checks++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_last_wait_cycle: busy=%b error=%b expected 1 0", busy, error);
        end
        tick();
        if (done) ndone++;
        checks++;
        if (busy !== 1'b0 || error !== 1'b1 || ndone !== 0) begin
            errors++;
            $display("FAIL timeout_flag: busy=%b error=%b dones=%0d expected 0 1 0", busy, error, ndone);
        end
        tick();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: error=%b expected 1", error);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (error !== 1'b0 || kexp_enable !== 1'b1 || round_num !== 4'd1) begin
            errors++;
            $display("FAIL timeout_restart: error=%b kexp_enable=%b round_num=%0d expected 0 1 1",
                     error, kexp_enable, round_num);
        end
        go_idle();
    endtask

    task automatic test_abort();
        int ken = -100, ren = -100;
        logic hit = 1'b0;
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (kexp_enable) ken = cyc;
            if (rnd_enable) begin
                ren = cyc;
                if (round_num == 4'd7) begin
                    hit = 1'b1;
                    break;
                end
            end
            kexp_done = (cyc == ken + 3);
            rnd_done  = (cyc == ren + 4);
            tick();
        end
        kexp_done = 1'b0;
        rnd_done  = 1'b0;
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL abort_reach_round7: reached=%b expected 1", hit);
        end
        tick();
        // abort and rnd_done together: abort must win
        abort    = 1'b1;
        rnd_done = 1'b1;
        tick();
        abort    = 1'b0;
        rnd_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || round_num !== 4'd7 || done !== 1'b0 || error !== 1'b0 || kexp_enable !== 1'b0) begin
            errors++;
            $display("FAIL abort_rnd_wait: busy=%b round_num=%0d done=%b error=%b kexp_enable=%b expected 0 7 0 0 0",
                     busy, round_num, done, error, kexp_enable);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_settled: busy=%b done=%b expected 0 0", busy, done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (round_num !== 4'd1 || kexp_enable !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: round_num=%0d kexp_enable=%b expected 1 1", round_num, kexp_enable);
        end
        go_idle();
    endtask

    task automatic test_stray();
        kexp_done = 1'b1;
        rnd_done  = 1'b1;
        tick();
        kexp_done = 1'b0;
        rnd_done  = 1'b0;
        checks++;
        if (busy !== 1'b0 || kexp_enable !== 1'b0 || rnd_enable !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: busy=%b kexp_enable=%b rnd_enable=%b expected 0 0 0", busy, kexp_enable, rnd_enable);
        end
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        // both dones in KEXP_WAIT: only kexp_done may act
        kexp_done = 1'b1;
        rnd_done  = 1'b1;
        tick();
        kexp_done = 1'b0;
        rnd_done  = 1'b0;
        tick();
        kexp_done = 1'b1;
        rnd_done  = 1'b1;
        start     = 1'b1;
        tick();
        kexp_done = 1'b0;
        rnd_done  = 1'b0;
        start     = 1'b0;
        checks++;
        if (round_num !== 4'd1 || kexp_enable !== 1'b0 || rnd_enable !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_hold: round_num=%0d kexp_enable=%b rnd_enable=%b busy=%b expected 1 0 0 1",
                     round_num, kexp_enable, rnd_enable, busy);
        end
        tick();
        tick();
        tick();
        checks++;
        if (cyc !== 8 || rnd_enable !== 1'b1) begin
            errors++;
            $display("FAIL stray_holdoff_kept: cycle %0d rnd_enable=%b expected cycle 8 rnd_enable 1", cyc, rnd_enable);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (round_num !== 4'd1 || kexp_enable !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_start_busy: round_num=%0d kexp_enable=%b busy=%b expected 1 0 1",
                     round_num, kexp_enable, busy);
        end
        rnd_done = 1'b1;
        tick();
        rnd_done = 1'b0;
        checks++;
        if (round_num !== 4'd2 || kexp_enable !== 1'b1) begin
            errors++;
            $display("FAIL stray_next_round: round_num=%0d kexp_enable=%b expected 2 1", round_num, kexp_enable);
        end
        go_idle();
    endtask

    task automatic test_async_rst();
        logic [9:0] outs;
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        kexp_done = 1'b1;
        tick();
        kexp_done = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || round_num !== 4'd1) begin
            errors++;
            $display("FAIL rst_pre_hold: busy=%b round_num=%0d expected 1 1", busy, round_num);
        end
        #2 rst = 1'b1;
        #1;
        outs = {round_num, kexp_enable, rnd_enable, rnd_last, busy, done, error};
        checks++;
        if (outs !== 10'b0) begin
            errors++;
            $display("FAIL rst_async_outputs: got %b expected 0000000000", outs);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        outs = {round_num, kexp_enable, rnd_enable, rnd_last, busy, done, error};
        checks++;
        if (outs !== 10'b0) begin
            errors++;
            $display("FAIL rst_release_outputs: got %b expected 0000000000", outs);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (kexp_enable !== 1'b1 || round_num !== 4'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart: kexp_enable=%b round_num=%0d busy=%b expected 1 1 1", kexp_enable, round_num, busy);
        end
        go_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_holdoff();
        test_timeout();
        test_abort();
        test_stray();
        test_async_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
